// File: rtl/vproc_mem_pkg.sv
// Shared types and helpers for the VProc64 memory responder.
// Holds the FSM state type, the out-of-window read pattern, LFSR taps and the byte-merge helper.
package vproc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [63:0] BADDATA   = 64'hDEAD_BEEF_DEAD_BEEF;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [63:0] merge64(input logic [63:0] old_word,
                                            input logic [63:0] new_word,
                                            input logic [7:0]  be);
        logic [63:0] res;
        res = old_word;
        for (int n = 0; n < 8; n++) begin
            if (be[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vproc_mem_lfsr16.sv
// 16-bit Fibonacci LFSR that supplies the random extra wait cycles.
// Latency: new value one edge after adv; no backpressure, steps only when adv is high.
// Backpressure: none; the caller decides when to advance.
module vproc_mem_lfsr16
    import vproc_mem_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       adv,
    output logic [1:0] rnd
);

    logic [15:0] value;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            value <= SEED;
        end else if (adv) begin
            value <= {value[14:0], ^(value & LFSR_TAPS)};
        end
    end

    assign rnd = value[1:0];

endmodule

// File: rtl/vproc64_mem_responder.sv
// VProc64 bus responder: single/burst reads and writes into a 64-bit word memory with byte merge.
// Latency: ack rises 1+WAIT_STATES edges after the request is sampled; at least 2 cycles per beat.
// Backpressure: WE/RD are held by the initiator until the ack; VPROC_MEM_RAND_WAIT_EN adds 0-3 random waits.
module vproc64_mem_responder
    import vproc_mem_pkg::*;
#(
    parameter int          MEM_ADDR_BITS = 12,
    parameter int          ADDR_SHIFT    = 0,
    parameter logic [63:0] BASE_ADDR     = 64'h0,
    parameter int          WAIT_STATES   = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [63:0] Addr,
    input  logic [7:0]  BE,
    input  logic        WE,
    input  logic        RD,
    input  logic [63:0] DataIn,
    output logic [63:0] DataOut,
    output logic        WRAck,
    output logic        RDAck,
    input  logic [11:0] Burst,
    input  logic        BurstFirst,
    input  logic        BurstLast,
    output logic        AddrErr,
    output logic        ProtErr
);

    localparam int DEPTH = 1 << MEM_ADDR_BITS;

    logic [63:0] mem [DEPTH];

    state_t                   state;
    logic [15:0]              wait_cnt;
    logic [11:0]              remaining;
    logic                     l_we;
    logic                     l_ok;
    logic                     l_perr;
    logic [MEM_ADDR_BITS-1:0] l_idx;
    logic [7:0]               l_be;
    logic [63:0]              l_dat;

    logic                     req_one;
    logic                     req_both;
    logic [63:0]              offset;
    logic [63:0]              shifted;
    logic                     in_win;
    logic [MEM_ADDR_BITS-1:0] idx;
    logic [11:0]              rem_eff;
    logic [11:0]              rem_next;
    logic                     frame_err;
    logic [15:0]              extra;
    logic [15:0]              wait_ld;

    logic                     acc_now;
    logic                     acc_we;
    logic                     acc_ok;
    logic                     acc_perr;
    logic [MEM_ADDR_BITS-1:0] acc_idx;
    logic [7:0]               acc_be;
    logic [63:0]              acc_dat;

    assign req_one  = WE ^ RD;
    assign req_both = WE & RD;

    assign offset  = Addr - BASE_ADDR;
    assign shifted = offset >> ADDR_SHIFT;
    assign in_win  = (Addr >= BASE_ADDR) && ((shifted >> MEM_ADDR_BITS) == 64'd0);
    assign idx     = shifted[MEM_ADDR_BITS-1:0];

    // A first beat restarts the count; framing is judged against the count that beat belongs to
    assign rem_eff   = BurstFirst ? Burst : remaining;
    assign rem_next  = (rem_eff != 12'd0) ? rem_eff - 12'd1 : 12'd0;
    assign frame_err = (BurstFirst && (remaining != 12'd0))
                     || (BurstFirst && (Burst == 12'd0))
                     || (BurstLast && (rem_eff != 12'd1))
                     || (!BurstLast && (rem_eff == 12'd1));

`ifdef VPROC_MEM_RAND_WAIT_EN
    logic [1:0] rnd;

    vproc_mem_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .adv   ((state == IDLE) && req_one),
        .rnd   (rnd)
    );

    assign extra = {14'd0, rnd};
`else
    assign extra = 16'd0;
`endif

    assign wait_ld = 16'(WAIT_STATES) + extra;

    // Zero-wait beats are serviced straight from the live inputs on the sample edge
    assign acc_now  = !Reset && (((state == IDLE) && req_one && (wait_ld == 16'd0))
                                || ((state == WAIT) && (wait_cnt == 16'd1)));
    assign acc_we   = (state == IDLE) ? WE        : l_we;
    assign acc_ok   = (state == IDLE) ? in_win    : l_ok;
    assign acc_perr = (state == IDLE) ? frame_err : l_perr;
    assign acc_idx  = (state == IDLE) ? idx       : l_idx;
    assign acc_be   = (state == IDLE) ? BE        : l_be;
    assign acc_dat  = (state == IDLE) ? DataIn    : l_dat;

    always_ff @(posedge Clk) begin
        if (acc_now && acc_we && acc_ok) begin
            mem[acc_idx] <= merge64(mem[acc_idx], acc_dat, acc_be);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            wait_cnt  <= 16'd0;
            remaining <= 12'd0;
            l_we      <= 1'b0;
            l_ok      <= 1'b0;
            l_perr    <= 1'b0;
            l_idx     <= '0;
            l_be      <= 8'd0;
            l_dat     <= 64'd0;
            DataOut   <= 64'd0;
            WRAck     <= 1'b0;
            RDAck     <= 1'b0;
            AddrErr   <= 1'b0;
            ProtErr   <= 1'b0;
        end else begin
            WRAck   <= 1'b0;
            RDAck   <= 1'b0;
            AddrErr <= 1'b0;
            ProtErr <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_both) begin
                        ProtErr <= 1'b1;
                    end else if (req_one) begin
                        l_we      <= WE;
                        l_ok      <= in_win;
                        l_perr    <= frame_err;
                        l_idx     <= idx;
                        l_be      <= BE;
                        l_dat     <= DataIn;
                        remaining <= rem_next;
                        if (wait_ld == 16'd0) begin
                            state <= ACK;
                        end else begin
                            wait_cnt <= wait_ld;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 16'd1;
                    if (wait_cnt == 16'd1) begin
                        state <= ACK;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (acc_now) begin
                WRAck   <= acc_we;
                RDAck   <= !acc_we;
                AddrErr <= !acc_ok;
                ProtErr <= acc_perr;
                if (!acc_we) begin
                    DataOut <= acc_ok ? mem[acc_idx] : BADDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_vproc64_mem_responder.sv
// Bench for vproc64_mem_responder: a zero-wait and a three-wait instance against a word-level reference model.
// Build with VPROC_MEM_RAND_WAIT_EN to also check the random extra waits.
module tb_vproc64_mem_responder;

    localparam longint unsigned DEPTH = 4096;
    localparam logic [15:0]     SEED  = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic [63:0] addr  [2];
    logic [63:0] din   [2];
    logic [63:0] dout  [2];
    logic [7:0]  be    [2];
    logic        we    [2];
    logic        rd    [2];
    logic        wrack [2];
    logic        rdack [2];
    logic [11:0] bn    [2];
    logic        bf    [2];
    logic        bl    [2];
    logic        aerr  [2];
    logic        perr  [2];

    int          n_vec = 0;
    int          n_err = 0;

    int          rem_m   [2];
    logic [15:0] lfsr_m  [2];
    logic [63:0] last_rd [2];
    logic [63:0] mem_m   [longint];

    always #5 clk = ~clk;

    vproc64_mem_responder #(.WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(rst[0]), .Addr(addr[0]), .BE(be[0]), .WE(we[0]), .RD(rd[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .WRAck(wrack[0]), .RDAck(rdack[0]),
        .Burst(bn[0]), .BurstFirst(bf[0]), .BurstLast(bl[0]), .AddrErr(aerr[0]), .ProtErr(perr[0])
    );

    vproc64_mem_responder #(.WAIT_STATES(3)) dut3 (
        .Clk(clk), .Reset(rst[1]), .Addr(addr[1]), .BE(be[1]), .WE(we[1]), .RD(rd[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .WRAck(wrack[1]), .RDAck(rdack[1]),
        .Burst(bn[1]), .BurstFirst(bf[1]), .BurstLast(bl[1]), .AddrErr(aerr[1]), .ProtErr(perr[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic longint key_of(input int d, input logic [63:0] a);
        return longint'(d) * 65536 + longint'(a);
    endfunction

    task automatic idle_inputs(input int d);
        we[d] = 1'b0; rd[d] = 1'b0; addr[d] = 64'd0; din[d] = 64'd0;
        be[d] = 8'd0; bn[d] = 12'd0; bf[d] = 1'b0; bl[d] = 1'b0;
    endtask

    // One beat: drive, wait for the ack, compare everything against the model, release.
    task automatic beat(input int d, input bit w, input logic [63:0] a, input logic [7:0] b,
                        input logic [63:0] dat, input bit first, input bit last, input logic [11:0] burst);
        int          ws;
        int          lat;
        int          reff;
        bit          got;
        bit          inwin;
        bit          exp_perr;
        logic [63:0] exp_rd;
        logic [63:0] old_w;
        longint      k;

        ws = (d == 0) ? 0 : 3;
`ifdef VPROC_MEM_RAND_WAIT_EN
        ws = ws + int'(lfsr_m[d][1:0]);
        lfsr_m[d] = lfsr_step(lfsr_m[d]);
`endif
        inwin = (a < DEPTH);
        k = key_of(d, a);

        exp_perr = 1'b0;
        if (first && rem_m[d] > 0) exp_perr = 1'b1;
        if (first && burst == 12'd0) exp_perr = 1'b1;
        reff = first ? int'(burst) : rem_m[d];
        if (last && reff != 1) exp_perr = 1'b1;
        if (!last && reff == 1) exp_perr = 1'b1;
        rem_m[d] = (reff > 0) ? reff - 1 : 0;

        @(negedge clk);
        we[d] = w; rd[d] = !w; addr[d] = a; be[d] = b; din[d] = dat;
        bf[d] = first; bl[d] = last; bn[d] = burst;

        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (wrack[d] || rdack[d]) got = 1'b1;
        end
        chk("ack_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(1 + ws));
        chk("wrack", 64'(wrack[d]), 64'(w));
        chk("rdack", 64'(rdack[d]), 64'(!w));
        chk("addrerr", 64'(aerr[d]), 64'(!inwin));
        chk("proterr", 64'(perr[d]), 64'(exp_perr));

        if (w) begin
            chk("dout_hold", dout[d], last_rd[d]);
            if (inwin) begin
                old_w = mem_m.exists(k) ? mem_m[k] : 64'd0;
                for (int n = 0; n < 8; n++) begin
                    if (b[n]) old_w[8*n +: 8] = dat[8*n +: 8];
                end
                mem_m[k] = old_w;
            end
        end else begin
            exp_rd = inwin ? mem_m[k] : 64'hDEAD_BEEF_DEAD_BEEF;
            chk("rdata", dout[d], exp_rd);
            last_rd[d] = exp_rd;
        end

        idle_inputs(d);
        @(posedge clk); #1;
        chk("ack_pulse", 64'(wrack[d] | rdack[d]), 64'd0);
    endtask

    task automatic rand_run(input int d, input int n);
        bit          w;
        bit          first;
        bit          last;
        logic [63:0] a;
        logic [7:0]  b;
        logic [11:0] burst;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = 64'h1000 + 64'($urandom_range(0, 255));
            else
                a = 64'h100 + 64'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            if (a < DEPTH && !mem_m.exists(key_of(d, a))) begin
                w = 1'b1;
                b = 8'hFF;
            end
            first = 1'b0; last = 1'b0; burst = 12'd0;
            if ($urandom_range(0, 7) == 0) begin
                first = 1'($urandom_range(0, 1));
                last  = 1'($urandom_range(0, 1));
                burst = 12'($urandom_range(0, 3));
            end
            beat(d, w, a, b, {$urandom, $urandom}, first, last, burst);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            idle_inputs(d);
            rem_m[d] = 0;
            lfsr_m[d] = SEED;
            last_rd[d] = 64'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_dout", dout[d], 64'd0);
            chk("rst_acks", 64'({wrack[d], rdack[d]}), 64'd0);
            chk("rst_errs", 64'({aerr[d], perr[d]}), 64'd0);
        end
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Single write then read
        beat(0, 1, 64'h10, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, 12'd0);
        beat(0, 0, 64'h10, 8'hFF, 64'd0, 0, 0, 12'd0);

        // Byte merge over an all-ones word
        beat(0, 1, 64'h11, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 12'd0);
        beat(0, 1, 64'h11, 8'h0F, 64'd0, 0, 0, 12'd0);
        beat(0, 0, 64'h11, 8'hFF, 64'd0, 0, 0, 12'd0);
        chk("merge_word", dout[0], 64'hFFFF_FFFF_0000_0000);

        // BE=0 writes nothing
        beat(0, 1, 64'h11, 8'h00, 64'h1234, 0, 0, 12'd0);
        beat(0, 0, 64'h11, 8'hFF, 64'd0, 0, 0, 12'd0);

        // Clean burst-4 write and read
        for (int i = 0; i < 4; i++)
            beat(0, 1, 64'h20 + 64'(i), 8'hFF, 64'hA5A5_0000_0000_0000 + 64'(i), i == 0, i == 3, 12'd4);
        for (int i = 0; i < 4; i++)
            beat(0, 0, 64'h20 + 64'(i), 8'hFF, 64'd0, i == 0, i == 3, 12'd4);

        // BurstLast one beat early
        for (int i = 0; i < 4; i++)
            beat(0, 0, 64'h20 + 64'(i), 8'hFF, 64'd0, i == 0, i == 2, 12'd4);

        // Burst of zero beats, and a first beat inside an open burst
        beat(0, 1, 64'h30, 8'hFF, 64'h5, 1, 0, 12'd0);
        beat(0, 1, 64'h31, 8'hFF, 64'h6, 1, 0, 12'd3);
        beat(0, 1, 64'h32, 8'hFF, 64'h7, 1, 0, 12'd2);
        beat(0, 1, 64'h33, 8'hFF, 64'h8, 0, 1, 12'd0);

        // Out-of-window access leaves word 0 alone
        beat(0, 1, 64'h0, 8'hFF, 64'h0BAD_F00D_0000_0001, 0, 0, 12'd0);
        beat(0, 1, 64'h1000, 8'hFF, 64'h1111_2222_3333_4444, 0, 0, 12'd0);
        beat(0, 0, 64'h1000, 8'hFF, 64'd0, 0, 0, 12'd0);
        beat(0, 0, 64'hFFFF_FFFF_0000_0000, 8'hFF, 64'd0, 0, 0, 12'd0);
        beat(0, 0, 64'h0, 8'hFF, 64'd0, 0, 0, 12'd0);

        // Simultaneous WE and RD
        @(negedge clk);
        we[0] = 1'b1; rd[0] = 1'b1; addr[0] = 64'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("both_proterr", 64'(perr[0]), 64'd1);
            chk("both_noack", 64'(wrack[0] | rdack[0]), 64'd0);
        end
        @(negedge clk);
        idle_inputs(0);
        @(posedge clk); #1;
        chk("both_clear", 64'(perr[0]), 64'd0);

        // Wait-state instance, then reset while a read is waiting
        beat(1, 1, 64'h5, 8'hFF, 64'hCAFE_0000_1234_5678, 0, 0, 12'd0);
        beat(1, 0, 64'h5, 8'hFF, 64'd0, 0, 0, 12'd0);
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 64'h5; be[1] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_noack", 64'(rdack[1]), 64'd0);
        rst[1] = 1'b1;
        #1;
        chk("mid_rst_dout", dout[1], 64'd0);
        chk("mid_rst_acks", 64'({wrack[1], rdack[1], aerr[1], perr[1]}), 64'd0);
        idle_inputs(1);
        rem_m[1] = 0;
        lfsr_m[1] = SEED;
        last_rd[1] = 64'd0;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("post_rst_noack", 64'(wrack[1] | rdack[1]), 64'd0);
        end
        beat(1, 0, 64'h5, 8'hFF, 64'd0, 0, 0, 12'd0);

        // Randomized traffic
        rand_run(0, 100);
        rand_run(1, 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
